// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow, asynchronous input signal in
// in_clk cycles and strobes period_valid once per completed period.
// Define FREQ_METER_DUTY_EN to also measure how many cycles the input was
// high within each period (high_cnt); otherwise high_cnt is tied to zero.
module freq_meter #(
    parameter int     CNT_W       = 33,
    parameter longint TIMEOUT     = 200000000,
    parameter int     SYNC_STAGES = 2
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic             timeout,
    output logic             measuring
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic                   rise;
    logic [0:0]             state;
    logic [CNT_W-1:0]       count;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;

    // Bring sig_in into the in_clk domain and keep one cycle of history for edge detection
    always_ff @(posedge in_clk) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev <= s_sync;
        end
    end

    // Period measurement: the first edge only arms, later edges report the cycle distance
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            measuring    <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        count     <= ONE;
                        state     <= MEASURE;
                        measuring <= 1'b1;
                    end else begin
                        count     <= '0;
                        measuring <= 1'b0;
                    end
                end
                default: begin
                    if (rise) begin
                        period       <= count;
                        period_valid <= 1'b1;
                        timeout      <= 1'b0;
                        count        <= ONE;
                        measuring    <= 1'b1;
                    end else if (count == TIMEOUT_CNT) begin
                        state     <= IDLE;
                        count     <= '0;
                        timeout   <= 1'b1;
                        measuring <= 1'b0;
                    end else begin
                        count     <= count + ONE;
                        measuring <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt;

    // High-time counter; the rise cycle itself is high, so a new window starts at 1
    always_ff @(posedge in_clk) begin
        if (reset) begin
            hcnt     <= '0;
            high_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hcnt <= rise ? ONE : '0;
                end
                default: begin
                    if (rise) begin
                        high_cnt <= hcnt;
                        hcnt     <= ONE;
                    end else if (count == TIMEOUT_CNT) begin
                        hcnt <= '0;
                    end else if (s_sync) begin
                        hcnt <= hcnt + ONE;
                    end
                end
            endcase
        end
    end
`else
    assign high_cnt = '0;
`endif

endmodule
